// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Optional build macro ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP.
module multicycle_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] instr,
    input  logic        BrEQ,
    input  logic        BrLT,
    output logic        PCSel,
    output logic        PCWen,
    output logic [3:0]  ImmSel,
    output logic        RegWen,
    output logic        BrUn,
    output logic        ASel,
    output logic        BSel,
    output logic [1:0]  ALU_op,
    output logic [3:0]  LoadType,
    output logic        LoadSigned,
    output logic        MemRW,
    output logic [1:0]  WBSel,
    output logic        LUI_Sel,
    output logic [2:0]  o_state,
    output logic        o_illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t      r_state;
    logic [31:0] r_ir;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic        w_is_jump;
    logic        w_known_op;
    logic        w_illegal;
    logic        w_br_taken;
    logic [3:0]  w_lsize;
    logic        w_in_body;
    logic        w_unused_ir;

    assign w_opcode    = r_ir[6:0];
    assign w_rd        = r_ir[11:7];
    assign w_funct3    = r_ir[14:12];
    assign w_unused_ir = ^r_ir[31:15];

    assign w_is_load   = (w_opcode == OPC_LOAD);
    assign w_is_store  = (w_opcode == OPC_STORE);
    assign w_is_branch = (w_opcode == OPC_BRANCH);
    assign w_is_jump   = (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR);
    assign w_in_body   = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    always_comb begin
        w_known_op = 1'b0;
        case (w_opcode)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH: w_known_op = 1'b1;
            default:                                  w_known_op = 1'b0;
        endcase
    end

    assign w_illegal = !w_known_op ||
                       (w_is_load && ((w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                      (w_funct3 == 3'b111)));

    always_comb begin
        w_lsize = 4'b0000;
        case (w_funct3)
            3'b000, 3'b100: w_lsize = 4'b0001;
            3'b001, 3'b101: w_lsize = 4'b0011;
            3'b010:         w_lsize = 4'b1111;
            default:        w_lsize = 4'b0000;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:         w_br_taken = BrEQ;
            3'b001:         w_br_taken = !BrEQ;
            3'b100, 3'b110: w_br_taken = BrLT;
            3'b101, 3'b111: w_br_taken = !BrLT;
            default:        w_br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= instr;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
`else
                        r_state   <= S_WB;
`endif
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else if (w_is_branch) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM:    r_state <= w_is_load ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from the registered state and latched instruction, so reset
    // zeroes them at once and branch PCSel can follow the same-cycle compare flags.
    always_comb begin
        PCSel      = 1'b0;
        PCWen      = 1'b0;
        ImmSel     = 4'b0000;
        RegWen     = 1'b0;
        BrUn       = 1'b0;
        ASel       = 1'b0;
        BSel       = 1'b0;
        ALU_op     = 2'b00;
        LoadType   = 4'b0000;
        LoadSigned = 1'b0;
        MemRW      = 1'b0;
        WBSel      = 2'b00;
        LUI_Sel    = 1'b0;

        if (w_in_body && !w_illegal) begin
            case (w_opcode)
                OPC_OP: begin
                    ALU_op = 2'b01;
                    WBSel  = 2'b01;
                end
                OPC_OPIMM: begin
                    BSel   = 1'b1;
                    ALU_op = 2'b01;
                    WBSel  = 2'b01;
                end
                OPC_LUI: begin
                    ImmSel  = 4'b1000;
                    BSel    = 1'b1;
                    ALU_op  = 2'b10;
                    LUI_Sel = 1'b1;
                    WBSel   = 2'b01;
                end
                OPC_AUIPC: begin
                    ASel   = 1'b1;
                    BSel   = 1'b1;
                    ImmSel = 4'b1000;
                    WBSel  = 2'b01;
                end
                OPC_JAL: begin
                    ASel   = 1'b1;
                    BSel   = 1'b1;
                    ImmSel = 4'b0100;
                    WBSel  = 2'b10;
                end
                OPC_JALR: begin
                    BSel  = 1'b1;
                    WBSel = 2'b10;
                end
                OPC_BRANCH: begin
                    ASel   = 1'b1;
                    BSel   = 1'b1;
                    ImmSel = 4'b0010;
                    BrUn   = w_funct3[1];
                end
                OPC_LOAD: begin
                    BSel       = 1'b1;
                    LoadType   = w_lsize;
                    LoadSigned = !w_funct3[2];
                    WBSel      = 2'b00;
                end
                OPC_STORE: begin
                    BSel     = 1'b1;
                    ImmSel   = 4'b0001;
                    LoadType = w_lsize;
                end
                default: ;
            endcase
        end

        case (r_state)
            S_EXEC: begin
                if (w_is_branch) begin
                    PCWen = 1'b1;
                    PCSel = w_br_taken;
                end
            end
            S_MEM: begin
                if (w_is_store) begin
                    PCWen = 1'b1;
                    MemRW = 1'b1;
                end
            end
            S_WB: begin
                PCWen  = 1'b1;
                RegWen = !w_illegal && (w_rd != 5'd0);
                PCSel  = !w_illegal && w_is_jump;
            end
            default: ;
        endcase
    end

    assign o_state   = r_state;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver pushes expected per-instruction results,
// monitor pops and checks them on each PCWen pulse.
module tb_multicycle_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] instr = '0;
    logic        BrEQ = 1'b0;
    logic        BrLT = 1'b0;
    logic        PCSel, PCWen, RegWen, BrUn, ASel, BSel, LoadSigned, MemRW, LUI_Sel, o_illegal;
    logic [3:0]  ImmSel, LoadType;
    logic [1:0]  ALU_op, WBSel;
    logic [2:0]  o_state;

    always #5 i_clk = ~i_clk;

    multicycle_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .instr(instr), .BrEQ(BrEQ), .BrLT(BrLT),
        .PCSel(PCSel), .PCWen(PCWen), .ImmSel(ImmSel), .RegWen(RegWen), .BrUn(BrUn),
        .ASel(ASel), .BSel(BSel), .ALU_op(ALU_op), .LoadType(LoadType),
        .LoadSigned(LoadSigned), .MemRW(MemRW), .WBSel(WBSel), .LUI_Sel(LUI_Sel),
        .o_state(o_state), .o_illegal(o_illegal)
    );

    logic [19:0] outv;
    assign outv = {PCSel, ImmSel, RegWen, BrUn, ASel, BSel, ALU_op, LoadType,
                   LoadSigned, MemRW, WBSel, LUI_Sel};

    typedef struct packed {
        logic [19:0] outv;
        logic [31:0] trace;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b0;
    bit   abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal_opcode(input logic [6:0] op);
        return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
    endfunction

    // Reference: per-instruction list of visited states plus the outputs seen in the
    // cycle that carries the PC write.
    function automatic exp_t model(input logic [31:0] ins, input logic eq, input logic lt);
        logic [6:0] op;
        logic [2:0] f3;
        logic       wr, pcsel, regwen, brun, asel, bsel, lsg, mrw, lui;
        logic [3:0] imm, size;
        logic [1:0] aluop, wb;
        int         path[$];
        exp_t       e;
        op = ins[6:0];
        f3 = ins[14:12];
        wr = (ins[11:7] != 5'd0);
        {pcsel, regwen, brun, asel, bsel, lsg, mrw, lui} = '0;
        imm = '0; aluop = '0; wb = '0;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 4'h1 :
               (f3 == 3'd1 || f3 == 3'd5) ? 4'h3 : (f3 == 3'd2) ? 4'hF : 4'h0;
        path = '{0, 1, 2, 4};
        case (op)
            7'h33: begin aluop = 2'b01; wb = 2'b01; regwen = wr; end
            7'h13: begin bsel = 1; aluop = 2'b01; wb = 2'b01; regwen = wr; end
            7'h37: begin imm = 4'b1000; bsel = 1; aluop = 2'b10; lui = 1; wb = 2'b01; regwen = wr; end
            7'h17: begin asel = 1; bsel = 1; imm = 4'b1000; wb = 2'b01; regwen = wr; end
            7'h6F: begin asel = 1; bsel = 1; imm = 4'b0100; wb = 2'b10; pcsel = 1; regwen = wr; end
            7'h67: begin bsel = 1; wb = 2'b10; pcsel = 1; regwen = wr; end
            7'h63: begin
                asel = 1; bsel = 1; imm = 4'b0010; brun = f3[1];
                case (f3)
                    3'd0: pcsel = eq;
                    3'd1: pcsel = !eq;
                    3'd4, 3'd6: pcsel = lt;
                    3'd5, 3'd7: pcsel = !lt;
                    default: pcsel = 0;
                endcase
                path = '{0, 1, 2};
            end
            7'h03: begin
                if (!(f3 inside {3'd3, 3'd6, 3'd7})) begin
                    bsel = 1; size = size; lsg = (f3 <= 3'd2); regwen = wr;
                    path = '{0, 1, 2, 3, 4};
                end else begin
                    size = 4'h0;
                end
            end
            7'h23: begin imm = 4'b0001; bsel = 1; mrw = 1; path = '{0, 1, 2, 3}; end
            default: ;
        endcase
        if (op != 7'h03 && op != 7'h23) size = 4'h0;
        e.outv = {pcsel, imm, regwen, brun, asel, bsel, aluop, size, lsg, mrw, wb, lui};
        e.trace = 0;
        foreach (path[i]) e.trace = e.trace * 8 + 32'(path[i] + 1);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0]  ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  bad_f3[3] = '{3'd3, 3'd6, 3'd7};
        int k;
        r = $urandom;
`ifdef ILLEGAL_TRAP_EN
        k = $urandom_range(0, 8);
`else
        k = $urandom_range(0, 9);
`endif
        case (k)
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r[6:0] = 7'h6F;
            5: r[6:0] = 7'h67;
            6: begin r[6:0] = 7'h63; r[14:12] = br_f3[$urandom_range(0, 5)]; end
            7: begin r[6:0] = 7'h03; r[14:12] = ld_f3[$urandom_range(0, 4)]; end
            8: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    r[6:0] = 7'h03;
                    r[14:12] = bad_f3[$urandom_range(0, 2)];
                end else begin
                    for (int t = 0; t < 64 && legal_opcode(r[6:0]); t++) r[6:0] = 7'($urandom);
                    if (legal_opcode(r[6:0])) r[6:0] = 7'h7F;
                end
            end
        endcase
        if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic eq, input logic lt);
        instr = ins;
        BrEQ  = eq;
        BrLT  = lt;
        sb.push_back(model(ins, eq, lt));
    endtask

    task automatic wait_done();
        int tgt;
        tgt = done_cnt + 1;
        for (int c = 0; c < 16 && done_cnt < tgt; c++) begin
            @(negedge i_clk);
            #1;
        end
        checks++;
        if (done_cnt < tgt) begin
            failures++;
            abort = 1'b1;
            $display("FAIL completion_timeout done=%0d expected=%0d", done_cnt, tgt);
        end
    endtask

    initial begin : monitor
        exp_t        e;
        int unsigned tr;
        int          ncyc;
        tr = 0;
        ncyc = 0;
        forever begin
            @(negedge i_clk);
            if (!mon_en || !i_reset) begin
                tr = 0;
                ncyc = 0;
            end else begin
                tr = tr * 8 + 32'(o_state) + 1;
                ncyc++;
                if (ncyc <= 2) chk("fetch_decode_zero", {11'd0, PCWen, outv}, 32'd0);
                if (!PCWen) begin
                    chk("write_before_final", {30'd0, RegWen, MemRW}, 32'd0);
                end else if (sb.size() == 0) begin
                    chk("unexpected_pcwen", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("state_trace", tr, e.trace);
                    chk("final_outputs", {12'd0, outv}, {12'd0, e.outv});
                    chk("illegal_flag", {31'd0, o_illegal}, 32'd0);
                    done_cnt++;
                    tr = 0;
                    ncyc = 0;
                end
            end
        end
    end

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog time limit reached");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] dir_ins[6] = '{32'h00A00093, 32'h10000637, 32'h00E61023,
                                    32'h00061783, 32'h00000063, 32'h00000063};
        logic        dir_eq[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bool_t_dummy : begin end
        repeat (3) @(negedge i_clk);
        chk("reset_state", {29'd0, o_state}, 32'd0);
        chk("reset_outputs", {11'd0, PCWen, outv}, 32'd0);
        chk("reset_illegal", {31'd0, o_illegal}, 32'd0);

        issue(dir_ins[0], dir_eq[0], 1'b0);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        mon_en = 1'b1;
        wait_done();
        for (int i = 1; i < 6 && !abort; i++) begin
            issue(dir_ins[i], dir_eq[i], 1'b0);
            wait_done();
        end
`ifndef ILLEGAL_TRAP_EN
        if (!abort) begin
            issue(32'hFFFFFFFF, 1'b0, 1'b0);
            wait_done();
        end
`endif

        // Reset in the MEM cycle of a store must kill MemRW without a clock edge.
        if (!abort) begin
            mon_en = 1'b0;
            instr = 32'h00E61023;
            for (int c = 0; c < 16 && o_state != 3'd3; c++) @(negedge i_clk);
            chk("abort_reached_mem", {29'd0, o_state}, 32'd3);
            chk("abort_memrw_before", {31'd0, MemRW}, 32'd1);
            #1 i_reset = 1'b0;
            #1;
            chk("abort_memrw_async", {31'd0, MemRW}, 32'd0);
            chk("abort_state_async", {29'd0, o_state}, 32'd0);
            chk("abort_outputs", {11'd0, PCWen, outv}, 32'd0);
            repeat (2) @(negedge i_clk);
            chk("abort_hold_state", {29'd0, o_state}, 32'd0);
            issue(32'h00061783, 1'b0, 1'b0);
            @(posedge i_clk);
            #1 i_reset = 1'b1;
            chk("release_state", {29'd0, o_state}, 32'd0);
            mon_en = 1'b1;
            wait_done();
        end

        for (int n = 0; n < 250 && !abort; n++) begin
            issue(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done();
        end

`ifdef ILLEGAL_TRAP_EN
        if (!abort) begin
            logic seen;
            mon_en = 1'b0;
            #1 i_reset = 1'b0;
            instr = 32'hFFFFFFFF;
            @(posedge i_clk);
            #1 i_reset = 1'b1;
            seen = 1'b0;
            repeat (12) begin
                @(negedge i_clk);
                seen = seen | PCWen | RegWen | MemRW;
            end
            chk("trap_no_enables", {31'd0, seen}, 32'd0);
            chk("trap_state", {29'd0, o_state}, 32'd5);
            chk("trap_illegal_set", {31'd0, o_illegal}, 32'd1);
            #1 i_reset = 1'b0;
            #1;
            chk("trap_reset_clears", {28'd0, o_state, o_illegal}, 32'd0);
        end
`endif

        repeat (2) @(negedge i_clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        summary();
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports:
- i_clk  in  1  sole clock; all flops on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word from instruction memory at the current PC.
- BrEQ  in  1  datapath branch compare, equal.
- BrLT  in  1  datapath branch compare, less-than; signed or unsigned per BrUn.
- PCSel  out  1  0 = PC+4, 1 = ALU result.
- PCWen  out  1  PC register write enable.
- ImmSel  out  4  immediate format: I=0000, S=0001, B=0010, J=0100, U=1000.
- RegWen  out  1  register file write enable.
- BrUn  out  1  unsigned branch compare.
- ASel  out  1  ALU A operand: 0 = rs1, 1 = PC.
- BSel  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- ALU_op  out  2  00 = add, 01 = decode funct3/funct7, 10 = pass B.
- LoadType  out  4  byte mask: 0001 = byte, 0011 = half, 1111 = word.
- LoadSigned  out  1  sign-extend the load result.
- MemRW  out  1  1 = data memory write.
- WBSel  out  2  00 = memory, 01 = ALU, 10 = PC+4.
- LUI_Sel  out  1  zero the ALU A operand for LUI.
- o_state  out  3  current FSM state, for debug.
- o_illegal  out  1  sticky illegal-instruction flag.

Function
REQ-002 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-003 FETCH SHALL always go to DECODE.
REQ-004 DECODE SHALL latch instr into an internal register, and all later states SHALL decode from that register only.
REQ-005 DECODE SHALL always go to EXEC.
REQ-006 EXEC SHALL transition by opcode:
- load/store -> MEM.
- OP, OP-IMM, LUI, AUIPC, JAL, JALR -> WB.
- BRANCH -> FETCH.
REQ-007 MEM SHALL go to WB for loads and to FETCH for stores.
REQ-008 WB SHALL always go to FETCH.
REQ-009 Instruction latency SHALL be: ALU, U-type and jumps 4 cycles; loads 5 cycles; stores 4 cycles; branches 3 cycles.
REQ-010 PCWen SHALL be high for exactly one cycle per instruction, in its final state (WB, MEM for stores, EXEC for branches), and low in every other cycle.
REQ-011 RegWen SHALL be high only in WB, and only if rd != 0.
REQ-012 MemRW SHALL be high only in MEM for stores.
REQ-013 ImmSel, ASel, BSel, ALU_op, BrUn, LUI_Sel and LoadType SHALL be driven from the latched instruction in EXEC, MEM and WB, and SHALL be 0 in FETCH and DECODE.
REQ-014 OP SHALL drive BSel=0, ALU_op=01, WBSel=01.
REQ-015 OP-IMM SHALL drive BSel=1, ImmSel=I, ALU_op=01, WBSel=01.
REQ-016 LUI SHALL drive ImmSel=U, BSel=1, ALU_op=10, LUI_Sel=1, WBSel=01.
REQ-017 AUIPC SHALL drive ASel=1, BSel=1, ImmSel=U, ALU_op=00.
REQ-018 Loads SHALL drive ImmSel=I, ALU_op=00, WBSel=00; stores SHALL drive ImmSel=S, ALU_op=00.
REQ-019 funct3 SHALL set LoadType: 000/100 -> 0001, 001/101 -> 0011, 010 -> 1111; LoadSigned=1 only for funct3 000/001/010.
REQ-020 JAL SHALL drive ASel=1, ImmSel=J; JALR SHALL drive ASel=0, ImmSel=I; both SHALL drive BSel=1, ALU_op=00, WBSel=10 and PCSel=1 in WB.
REQ-021 Branches SHALL drive ASel=1, BSel=1, ImmSel=B, ALU_op=00 and BrUn=funct3[1].
REQ-022 PCSel for branches SHALL be evaluated in EXEC from the same-cycle BrEQ/BrLT: BEQ on EQ, BNE on !EQ, BLT/BLTU on LT, BGE/BGEU on !LT.
REQ-023 An unsupported opcode, or a load funct3 of 011/110/111, SHALL be illegal.

Reset
REQ-024 Assertion of i_reset SHALL immediately force state=FETCH, clear the instruction register, drive every output to 0 and clear o_illegal.
REQ-025 Reset asserted mid-instruction SHALL abort it with no PCWen, RegWen or MemRW pulse.
REQ-026 Following deassertion, the first rising edge SHALL move the FSM to DECODE.

Configuration
REQ-027 With ILLEGAL_TRAP_EN defined, an illegal instruction in EXEC SHALL go to TRAP and set o_illegal.
REQ-028 TRAP SHALL hold with all enables low until reset.
REQ-029 Without ILLEGAL_TRAP_EN, an illegal instruction SHALL go EXEC -> WB with RegWen=0 and PCWen=1 (a NOP), and o_illegal SHALL stay 0.

Verification
REQ-030 Reset then instr=0x00A00093 (ADDI x1,x0,10) -> states 0,1,2,4; in WB RegWen=1, BSel=1, ALU_op=01, WBSel=01, PCWen=1.
REQ-031 instr=0x10000637 (LUI x12) -> in WB ImmSel=1000, ALU_op=10, LUI_Sel=1, RegWen=1.
REQ-032 SH x14,0(x12), then LH x15,0(x12) -> SH: MEM has MemRW=1, LoadType=0011, PCWen=1, no WB. LH: 5 cycles, WBSel=00, LoadSigned=1, RegWen=1 in WB only.
REQ-033 BEQ with BrEQ=1, then with BrEQ=0 -> PCSel=1, then 0; PCWen pulses in EXEC; 3 cycles each.
REQ-034 i_reset low during MEM of a store -> MemRW drops without a clock edge, and state=0 after release.
REQ-035 instr=0xFFFFFFFF -> with the macro defined, state=5, o_illegal=1, PCWen stays 0; without it, a 4-cycle NOP with RegWen=0.
